// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC register, start/halt/stall/redirect sequencing and retired-instruction count.
// Optional branch_count output enabled by defining PC_SEQ_BRANCH_CNT_EN.
module pc_sequencer #(
  parameter int unsigned PC_W     = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [PC_W-1:0]  target,
  output logic [PC_W-1:0]  pc,
  output logic             pc_valid,
  output logic             done,
`ifdef PC_SEQ_BRANCH_CNT_EN
  output logic [CNT_W-1:0] branch_count,
`endif
  output logic [CNT_W-1:0] insn_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [PC_W-1:0]  PC_RST  = PC_W'(RESET_PC);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q,    state_d;
  logic [PC_W-1:0]  pc_q,       pc_d;
  logic             valid_q,    valid_d;
  logic             done_q,     done_d;
  logic [CNT_W-1:0] icnt_q,     icnt_d;
  logic             pend_q,     pend_d;
  logic [PC_W-1:0]  pend_tgt_q, pend_tgt_d;
`ifdef PC_SEQ_BRANCH_CNT_EN
  logic [CNT_W-1:0] bcnt_q,     bcnt_d;
`endif

  // Saturating increments for the retired-instruction and redirect counters
  logic [CNT_W-1:0] icnt_inc;
  assign icnt_inc = (icnt_q == CNT_MAX) ? icnt_q : icnt_q + CNT_W'(1);
`ifdef PC_SEQ_BRANCH_CNT_EN
  logic [CNT_W-1:0] bcnt_inc;
  assign bcnt_inc = (bcnt_q == CNT_MAX) ? bcnt_q : bcnt_q + CNT_W'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= PC_RST;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      icnt_q     <= '0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
`ifdef PC_SEQ_BRANCH_CNT_EN
      bcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      icnt_q     <= icnt_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
`ifdef PC_SEQ_BRANCH_CNT_EN
      bcnt_q     <= bcnt_d;
`endif
    end
  end

  // Next-state logic; RUN priority: halt, stall, fresh branch, pending redirect, sequential
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    done_d     = done_q;
    icnt_d     = icnt_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
`ifdef PC_SEQ_BRANCH_CNT_EN
    bcnt_d     = bcnt_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (halt_req && !stall) begin
          state_d = ST_HALTED;
          valid_d = 1'b0;
          done_d  = 1'b1;
          pend_d  = 1'b0;
        end else if (stall) begin
          if (branch_en) begin
            pend_d     = 1'b1;
            pend_tgt_d = target;
          end
        end else if (branch_en) begin
          pc_d   = target;
          pend_d = 1'b0;
          icnt_d = icnt_inc;
`ifdef PC_SEQ_BRANCH_CNT_EN
          bcnt_d = bcnt_inc;
`endif
        end else if (pend_q) begin
          pc_d   = pend_tgt_q;
          pend_d = 1'b0;
          icnt_d = icnt_inc;
`ifdef PC_SEQ_BRANCH_CNT_EN
          bcnt_d = bcnt_inc;
`endif
        end else begin
          pc_d   = pc_q + PC_W'(1);
          icnt_d = icnt_inc;
        end
      end
      default: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = PC_RST;
          valid_d = 1'b1;
          done_d  = 1'b0;
          icnt_d  = '0;
          pend_d  = 1'b0;
`ifdef PC_SEQ_BRANCH_CNT_EN
          bcnt_d  = '0;
`endif
        end
      end
    endcase
  end

  assign pc         = pc_q;
  assign pc_valid   = valid_q;
  assign done       = done_q;
  assign insn_count = icnt_q;
`ifdef PC_SEQ_BRANCH_CNT_EN
  assign branch_count = bcnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters; branch_count checked when PC_SEQ_BRANCH_CNT_EN is defined).
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic        stall;
  logic        branch_en;
  logic [15:0] target;
  logic [15:0] pc;
  logic        pc_valid;
  logic        done;
  logic [15:0] insn_count;
`ifdef PC_SEQ_BRANCH_CNT_EN
  logic [15:0] branch_count;
`endif

  int n_checks;
  int n_fail;

  pc_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .halt_req   (halt_req),
    .stall      (stall),
    .branch_en  (branch_en),
    .target     (target),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .done       (done),
`ifdef PC_SEQ_BRANCH_CNT_EN
    .branch_count (branch_count),
`endif
    .insn_count (insn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_and_start();
    rst_n = 1'b0;
    start = 1'b0; halt_req = 1'b0; stall = 1'b0; branch_en = 1'b0; target = '0;
    #2;
    rst_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; halt_req = 1'b0; stall = 1'b0; branch_en = 1'b0; target = '0;
    #3;
    n_checks++;
    if (pc !== 16'h0000 || pc_valid !== 1'b0 || done !== 1'b0 || insn_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_values: pc=%h valid=%b done=%b cnt=%0d expected pc=0000 valid=0 done=0 cnt=0",
               pc, pc_valid, done, insn_count);
    end
    rst_n = 1'b1;
    step();
    branch_en = 1'b1; target = 16'h0005; halt_req = 1'b1; stall = 1'b1;
    step();
    step();
    branch_en = 1'b0; halt_req = 1'b0; stall = 1'b0;
    n_checks++;
    if (pc !== 16'h0000 || pc_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_inputs: pc=%h valid=%b done=%b expected pc=0000 valid=0 done=0",
               pc, pc_valid, done);
    end
  endtask

  task automatic test_sequential();
    logic [15:0] exp_pc [5];
    reset_and_start();
    exp_pc = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (pc !== exp_pc[i] || pc_valid !== 1'b1 || insn_count !== 16'(i)) begin
        n_fail++;
        $display("FAIL seq_%0d: pc=%h valid=%b cnt=%0d expected pc=%h valid=1 cnt=%0d",
                 i, pc, pc_valid, insn_count, exp_pc[i], i);
      end
      if (i < 4) step();
    end
  endtask

  task automatic test_branch();
    reset_and_start();
    step(); step(); step();
    branch_en = 1'b1; target = 16'h0065;
    step();
    branch_en = 1'b0; target = 16'hxxxx;
    n_checks++;
    if (pc !== 16'h0065 || insn_count !== 16'd4) begin
      n_fail++;
      $display("FAIL branch_redirect: pc=%h cnt=%0d expected pc=0065 cnt=4", pc, insn_count);
    end
`ifdef PC_SEQ_BRANCH_CNT_EN
    n_checks++;
    if (branch_count !== 16'd1) begin
      n_fail++;
      $display("FAIL branch_count_1: got %0d expected 1", branch_count);
    end
`endif
    step();
    n_checks++;
    if (pc !== 16'h0066 || insn_count !== 16'd5) begin
      n_fail++;
      $display("FAIL branch_follow: pc=%h cnt=%0d expected pc=0066 cnt=5", pc, insn_count);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (pc !== 16'h0067 || insn_count !== 16'd6) begin
      n_fail++;
      $display("FAIL start_in_run_ignored: pc=%h cnt=%0d expected pc=0067 cnt=6", pc, insn_count);
    end
  endtask

  task automatic test_stall();
    reset_and_start();
    branch_en = 1'b1; target = 16'h0010;
    step();
    stall = 1'b1; target = 16'h004C;
    step();
    target = 16'h0083;
    step();
    branch_en = 1'b0; halt_req = 1'b1;
    step();
    n_checks++;
    if (pc !== 16'h0010 || insn_count !== 16'd1 || pc_valid !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hold: pc=%h cnt=%0d valid=%b done=%b expected pc=0010 cnt=1 valid=1 done=0",
               pc, insn_count, pc_valid, done);
    end
    stall = 1'b0; halt_req = 1'b0;
    step();
    n_checks++;
    if (pc !== 16'h0083 || insn_count !== 16'd2) begin
      n_fail++;
      $display("FAIL stall_last_pending: pc=%h cnt=%0d expected pc=0083 cnt=2", pc, insn_count);
    end
`ifdef PC_SEQ_BRANCH_CNT_EN
    n_checks++;
    if (branch_count !== 16'd2) begin
      n_fail++;
      $display("FAIL branch_count_stall: got %0d expected 2", branch_count);
    end
`endif
    step();
    n_checks++;
    if (pc !== 16'h0084 || insn_count !== 16'd3) begin
      n_fail++;
      $display("FAIL after_pending: pc=%h cnt=%0d expected pc=0084 cnt=3", pc, insn_count);
    end
    stall = 1'b1; branch_en = 1'b1; target = 16'h0020;
    step();
    stall = 1'b0; target = 16'h0030;
    step();
    branch_en = 1'b0;
    n_checks++;
    if (pc !== 16'h0030 || insn_count !== 16'd4) begin
      n_fail++;
      $display("FAIL fresh_beats_pending: pc=%h cnt=%0d expected pc=0030 cnt=4", pc, insn_count);
    end
    step();
    n_checks++;
    if (pc !== 16'h0031) begin
      n_fail++;
      $display("FAIL pending_cleared_by_fresh: pc=%h expected pc=0031", pc);
    end
  endtask

  task automatic test_wrap();
    reset_and_start();
    branch_en = 1'b1; target = 16'hFFFF;
    step();
    branch_en = 1'b0;
    n_checks++;
    if (pc !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_load: pc=%h expected pc=ffff", pc);
    end
    step();
    n_checks++;
    if (pc !== 16'h0000 || pc_valid !== 1'b1 || insn_count !== 16'd2) begin
      n_fail++;
      $display("FAIL wrap_roll: pc=%h valid=%b cnt=%0d expected pc=0000 valid=1 cnt=2",
               pc, pc_valid, insn_count);
    end
  endtask

  task automatic test_halt();
    reset_and_start();
    branch_en = 1'b1; target = 16'h0025;
    step();
    halt_req = 1'b1; target = 16'h0099;
    step();
    halt_req = 1'b0; branch_en = 1'b0;
    n_checks++;
    if (pc !== 16'h0025 || done !== 1'b1 || pc_valid !== 1'b0 || insn_count !== 16'd1) begin
      n_fail++;
      $display("FAIL halt_enter: pc=%h done=%b valid=%b cnt=%0d expected pc=0025 done=1 valid=0 cnt=1",
               pc, done, pc_valid, insn_count);
    end
    branch_en = 1'b1; target = 16'h0042;
    step();
    branch_en = 1'b0;
    step();
    n_checks++;
    if (pc !== 16'h0025 || done !== 1'b1 || pc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_sticky: pc=%h done=%b valid=%b expected pc=0025 done=1 valid=0",
               pc, done, pc_valid);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (pc !== 16'h0000 || done !== 1'b0 || pc_valid !== 1'b1 || insn_count !== 16'd0) begin
      n_fail++;
      $display("FAIL halt_restart: pc=%h done=%b valid=%b cnt=%0d expected pc=0000 done=0 valid=1 cnt=0",
               pc, done, pc_valid, insn_count);
    end
`ifdef PC_SEQ_BRANCH_CNT_EN
    n_checks++;
    if (branch_count !== 16'd0) begin
      n_fail++;
      $display("FAIL branch_count_restart: got %0d expected 0", branch_count);
    end
`endif
    step();
    n_checks++;
    if (pc !== 16'h0001) begin
      n_fail++;
      $display("FAIL halt_no_stale_branch: pc=%h expected pc=0001", pc);
    end
  endtask

  task automatic test_async_reset();
    reset_and_start();
    step(); step();
    stall = 1'b1; branch_en = 1'b1; target = 16'h0077;
    step();
    branch_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pc !== 16'h0000 || pc_valid !== 1'b0 || done !== 1'b0 || insn_count !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h valid=%b done=%b cnt=%0d expected pc=0000 valid=0 done=0 cnt=0",
               pc, pc_valid, done, insn_count);
    end
    stall = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (pc !== 16'h0000 || pc_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_after_reset: pc=%h valid=%b expected pc=0000 valid=1", pc, pc_valid);
    end
    step();
    n_checks++;
    if (pc !== 16'h0001 || insn_count !== 16'd1) begin
      n_fail++;
      $display("FAIL no_stale_redirect: pc=%h cnt=%0d expected pc=0001 cnt=1", pc, insn_count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_wrap();
    test_halt();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
